id_ex_pipe: RTL
===============

Name: id_ex_pipe

Overview:
Parametrised ID/EX pipeline register for the MIPS core. It supersedes the plain-register ID/EX stage.
- Adds a valid bit, downstream stall (hold) and flush (bubble insertion).
- Adds built-in load-use hazard detection that auto-inserts a bubble.
- Sits between decode and execute; registers WB/MEM/EX control groups, operands, immediate, register-specifier fields and jump target.

Parameters:
DATA_W, 32, width of nextAddress, A, B, imm
REG_W, 5, width of each register-specifier field (Ins25/20/15/10)
TAR_W, 26, jump-target width
MEMREAD_BIT, 1, bit index of MemRead within the MEM control group

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold all registers (downstream stall)
flush  in  1  insert bubble (branch/jump redirect)
valid_in  in  1  decode-stage instruction valid
WB_in / WB_out  in/out  2  write-back control group
MEM_in / MEM_out  in/out  4  memory control group
EX_in  in  8  execute control group
nextAddress_in / nextAddress_out  in/out  DATA_W  PC+4
A_in / A_out, B_in / B_out  in/out  DATA_W  register operands
imm_in / imm_out  in/out  DATA_W  sign-extended immediate
Ins25_in/out, Ins20_in/out, Ins15_in/out, Ins10_in/out  in/out  REG_W  rs, rt, rd, shamt
tar_in / tar_out  in/out  TAR_W  jump target
id_rs, id_rt  in  REG_W  rs/rt of the instruction currently in decode
valid_out  out  1  EX-stage instruction valid
AluzeroCtr  out  3  EX_out[7:5]
RegDst  out  1  EX_out[4]
ALUop  out  3  EX_out[3:1]
ALUSrc  out  1  EX_out[0]
load_use_hazard  out  1  combinational; decode must hold IF/ID and PC
bubble_cnt  out  32  bubble counter (see Optional Feature)

Behaviour:
- Latency: 1 cycle, input to output.
- All outputs are registered except load_use_hazard and the EX field slices.
- Per-edge priority: reset > flush > stall > hazard bubble > load.
- reset:
  - all registers cleared to 0, including valid_out and bubble_cnt.
  - load_use_hazard = 0, since valid_out = 0.
- flush:
  - valid_out, WB_out, MEM_out and EX register cleared to 0.
  - data fields (nextAddress, A, B, imm, Ins*, tar) hold their previous values; these are don't-care under valid_out = 0.
  - flush overrides a simultaneous stall.
- stall (no flush):
  - every register holds, including valid_out.
  - the hazard bubble is suppressed.
- load_use_hazard = valid_out & MEM_out[MEMREAD_BIT] & (Ins20_out != 0) & ((Ins20_out == id_rs) | (Ins20_out == id_rt)).
- Hazard bubble: when load_use_hazard = 1 with no flush and no stall, the next edge loads a bubble. A bubble means control groups = 0 and valid_out = 0; data fields hold.
  - The external decode stage holds its instruction, so that instruction reloads on the following edge.
  - Hazard is therefore asserted for exactly one cycle per load-use pair.
- Load:
  - all *_out take the corresponding *_in; valid_out = valid_in.
  - when valid_in = 0, control groups are forced to 0 regardless of WB_in/MEM_in/EX_in.
- Register 0 never raises a hazard.
- Reset asserted mid-stall or mid-hazard: clears on that edge; no residual bubble afterwards.

Optional Feature:
Macro ID_EX_PERF_CNT_EN.
- Defined: bubble_cnt increments by 1 on every edge that loads a bubble.
  - Counts flush edges and hazard-bubble edges, not stalls and not reset.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset.
- Undefined: no counter logic; bubble_cnt tied to 0.

Decomposition:
- Shared package id_ex_pkg holds:
  - WB_W = 2, MEM_W = 4, EX_W = 8.
  - EX field bit positions: ALUZERO_HI = 7, ALUZERO_LO = 5, REGDST_BIT = 4, ALUOP_HI = 3, ALUOP_LO = 1, ALUSRC_BIT = 0.
  - Default MEMREAD_BIT.
- One sub-module, pipe_reg_en: a WIDTH-parametrised register with synchronous reset, hold enable and synchronous clear-to-zero.
  - Instantiated once per control group with clear.
  - Instantiated once per data field with clear unused.

Test Plan:
- Reset: reset = 1 with all inputs = 'hFF.. -> next edge all outputs 0, valid_out = 0, load_use_hazard = 0.
- Load: valid_in = 1, A_in = 32'h1234_5678, EX_in = 8'b101_1_010_1 -> next edge A_out = 32'h12345678, AluzeroCtr = 3'b101, RegDst = 1, ALUop = 3'b010, ALUSrc = 1, valid_out = 1.
- Stall: load a value, then stall = 1 for 3 cycles with new inputs -> outputs unchanged for all 3 cycles; new values appear 1 edge after stall drops.
- Flush beats stall: flush = 1 and stall = 1 on the same edge -> WB_out = 0, MEM_out = 0, EX slices 0, valid_out = 0; A_out retains its old value.
- Load-use:
  - Stimulus: a load is in EX (MEM_out[1] = 1, Ins20_out = 5'd8, valid_out = 1) while id_rs = 8.
  - Required: load_use_hazard = 1; next edge is a bubble (valid_out = 0) and hazard drops to 0.
  - Repeat with Ins20_out = 0 -> load_use_hazard = 0.
- ID_EX_PERF_CNT_EN: 2 flushes plus 1 hazard bubble, with 4 stall cycles interleaved -> bubble_cnt = 3.
  - Undefined -> bubble_cnt = 0 throughout.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared widths, EX control-field bit positions and the per-edge update kind
// for the ID/EX pipeline register.
package id_ex_pkg;

  localparam int WB_W  = 2;
  localparam int MEM_W = 4;
  localparam int EX_W  = 8;

  localparam int ALUZERO_HI = 7;
  localparam int ALUZERO_LO = 5;
  localparam int REGDST_BIT = 4;
  localparam int ALUOP_HI   = 3;
  localparam int ALUOP_LO   = 1;
  localparam int ALUSRC_BIT = 0;

  localparam int MEMREAD_BIT_DEFAULT = 1;

  // What the stage does on the coming edge (reset is handled separately).
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2
  } upd_e;

endpackage

// File: rtl/pipe_reg_en.sv
// Width-parametrised pipeline register: synchronous reset, synchronous clear
// to zero, and load enable (hold when en = 0). Priority reset > clr > en.
module pipe_reg_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid bit, stall/flush and load-use bubble.
// Optional bubble counter enabled by the ID_EX_PERF_CNT_EN macro.
module id_ex_pipe import id_ex_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int TAR_W       = 26,
  parameter int MEMREAD_BIT = MEMREAD_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [WB_W-1:0]   WB_in,
  output logic [WB_W-1:0]   WB_out,
  input  logic [MEM_W-1:0]  MEM_in,
  output logic [MEM_W-1:0]  MEM_out,
  input  logic [EX_W-1:0]   EX_in,
  input  logic [DATA_W-1:0] nextAddress_in,
  output logic [DATA_W-1:0] nextAddress_out,
  input  logic [DATA_W-1:0] A_in,
  output logic [DATA_W-1:0] A_out,
  input  logic [DATA_W-1:0] B_in,
  output logic [DATA_W-1:0] B_out,
  input  logic [DATA_W-1:0] imm_in,
  output logic [DATA_W-1:0] imm_out,
  input  logic [REG_W-1:0]  Ins25_in,
  output logic [REG_W-1:0]  Ins25_out,
  input  logic [REG_W-1:0]  Ins20_in,
  output logic [REG_W-1:0]  Ins20_out,
  input  logic [REG_W-1:0]  Ins15_in,
  output logic [REG_W-1:0]  Ins15_out,
  input  logic [REG_W-1:0]  Ins10_in,
  output logic [REG_W-1:0]  Ins10_out,
  input  logic [TAR_W-1:0]  tar_in,
  output logic [TAR_W-1:0]  tar_out,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  output logic              valid_out,
  output logic [2:0]        AluzeroCtr,
  output logic              RegDst,
  output logic [2:0]        ALUop,
  output logic              ALUSrc,
  output logic              load_use_hazard,
  output logic [31:0]       bubble_cnt
);

  // Stage handshake: valid_in qualifies the decode-stage instruction and is
  // captured on every edge that is not a hold. stall freezes the whole stage
  // (valid_out included); flush or a load-use hazard loads a bubble, i.e.
  // valid_out = 0 with zeroed control groups. While load_use_hazard is high the
  // decode stage must keep its instruction so it is presented again next edge.

  upd_e             upd;
  logic             ctrl_en;
  logic             ctrl_clr;
  logic             data_en;
  logic [EX_W-1:0]  ex_q;
  logic [WB_W-1:0]  wb_d;
  logic [MEM_W-1:0] mem_d;
  logic [EX_W-1:0]  ex_d;

  assign load_use_hazard = valid_out & MEM_out[MEMREAD_BIT] & (Ins20_out != '0) &
                           ((Ins20_out == id_rs) | (Ins20_out == id_rt));

  always_comb begin
    upd = UPD_LOAD;
    if (flush) begin
      upd = UPD_BUBBLE;
    end else if (stall) begin
      upd = UPD_HOLD;
    end else if (load_use_hazard) begin
      upd = UPD_BUBBLE;
    end
  end

  assign ctrl_en  = (upd != UPD_HOLD);
  assign ctrl_clr = (upd == UPD_BUBBLE);
  assign data_en  = (upd == UPD_LOAD);

  // An invalid decode slot never carries live control into EX.
  assign wb_d  = valid_in ? WB_in  : '0;
  assign mem_d = valid_in ? MEM_in : '0;
  assign ex_d  = valid_in ? EX_in  : '0;

  pipe_reg_en #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en(ctrl_en), .clr(ctrl_clr), .d(valid_in), .q(valid_out)
  );
  pipe_reg_en #(.WIDTH(WB_W)) u_wb (
    .clk(clk), .reset(reset), .en(ctrl_en), .clr(ctrl_clr), .d(wb_d), .q(WB_out)
  );
  pipe_reg_en #(.WIDTH(MEM_W)) u_mem (
    .clk(clk), .reset(reset), .en(ctrl_en), .clr(ctrl_clr), .d(mem_d), .q(MEM_out)
  );
  pipe_reg_en #(.WIDTH(EX_W)) u_ex (
    .clk(clk), .reset(reset), .en(ctrl_en), .clr(ctrl_clr), .d(ex_d), .q(ex_q)
  );

  // Data fields hold through bubbles; they are don't-care while valid_out = 0.
  pipe_reg_en #(.WIDTH(DATA_W)) u_next_address (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(nextAddress_in), .q(nextAddress_out)
  );
  pipe_reg_en #(.WIDTH(DATA_W)) u_a (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(A_in), .q(A_out)
  );
  pipe_reg_en #(.WIDTH(DATA_W)) u_b (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(B_in), .q(B_out)
  );
  pipe_reg_en #(.WIDTH(DATA_W)) u_imm (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(imm_in), .q(imm_out)
  );
  pipe_reg_en #(.WIDTH(REG_W)) u_ins25 (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(Ins25_in), .q(Ins25_out)
  );
  pipe_reg_en #(.WIDTH(REG_W)) u_ins20 (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(Ins20_in), .q(Ins20_out)
  );
  pipe_reg_en #(.WIDTH(REG_W)) u_ins15 (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(Ins15_in), .q(Ins15_out)
  );
  pipe_reg_en #(.WIDTH(REG_W)) u_ins10 (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(Ins10_in), .q(Ins10_out)
  );
  pipe_reg_en #(.WIDTH(TAR_W)) u_tar (
    .clk(clk), .reset(reset), .en(data_en), .clr(1'b0), .d(tar_in), .q(tar_out)
  );

  assign AluzeroCtr = ex_q[ALUZERO_HI:ALUZERO_LO];
  assign RegDst     = ex_q[REGDST_BIT];
  assign ALUop      = ex_q[ALUOP_HI:ALUOP_LO];
  assign ALUSrc     = ex_q[ALUSRC_BIT];

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Saturating count of bubble-loading edges (flush or load-use).
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (ctrl_clr && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule
